// File: rtl/jtag_ahb_pkg.sv
// Shared types and command-field layout for the JTAG-to-AHB request queue.
package jtag_ahb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  localparam int unsigned ADDR_LSB  = 0;
  localparam int unsigned WDATA_LSB = 32;
  localparam int unsigned WRITE_BIT = 64;
  localparam int unsigned CMD_W_DEF = 65;

endpackage

// File: rtl/jtag_cmd_fifo.sv
// Synchronous command FIFO; a push is accepted while full if a pop occurs on the same edge.
module jtag_cmd_fifo #(
  parameter int unsigned CMD_W = 65,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     push,
  input  logic                     pop,
  input  logic [CMD_W-1:0]         din,
  output logic [CMD_W-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [CMD_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && (!full || do_pop);
  assign full    = (count == (AW+1)'(DEPTH));
  assign head    = (count == '0) ? '0 : mem[rd_ptr];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/jtag_ahb_req_queue.sv
// Queues JTAG Update-DR commands and issues them one at a time to the AHB master,
// with per-transaction timeout abort and sticky overflow/timeout/error status.
module jtag_ahb_req_queue
  import jtag_ahb_pkg::*;
#(
  parameter int unsigned CMD_W   = CMD_W_DEF,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   update_dr,
  input  logic                   ahb_select,
  input  logic                   lsb_en,
  input  logic [CMD_W-1:0]       cmd_in,
  input  logic                   ack,
  input  logic                   err,
  input  logic                   clr_status,
  output logic                   ahb_enable,
  output logic [CMD_W-1:0]       cmd_out,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   full,
  output logic                   overflow_flag,
  output logic                   timeout_flag,
  output logic                   err_flag
);

  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] timer;
  logic          capture;
  logic          done_ack;
  logic          done_to;
  logic          pop;

  assign capture  = update_dr & ahb_select & lsb_en;
  assign done_ack = (state == REQ) & ack;
  // An ack on the expiry edge wins over the timeout.
  assign done_to  = (state == REQ) & ~ack & (TIMEOUT != 0) & (timer == T_LAST);
  assign pop      = done_ack | done_to;

  jtag_cmd_fifo #(
    .CMD_W (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .nRST  (nRST),
    .push  (capture),
    .pop   (pop),
    .din   (cmd_in),
    .head  (cmd_out),
    .count (pending),
    .full  (full)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (pending != '0) state_nxt = REQ;
      REQ:  if (pop)           state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ahb_enable = 1'b0;
    if (state == REQ) ahb_enable = 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)              timer <= '0;
    else if (state == IDLE) timer <= '0;
    else                    timer <= timer + 1'b1;
  end

  // Set events take priority over clr_status.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      overflow_flag <= 1'b0;
      timeout_flag  <= 1'b0;
      err_flag      <= 1'b0;
    end else begin
      if (capture && full && !pop) overflow_flag <= 1'b1;
      else if (clr_status)         overflow_flag <= 1'b0;
      if (done_to)                 timeout_flag  <= 1'b1;
      else if (clr_status)         timeout_flag  <= 1'b0;
      if (done_ack && err)         err_flag      <= 1'b1;
      else if (clr_status)         err_flag      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtag_ahb_req_queue.sv
// Directed bench for jtag_ahb_req_queue with DEPTH=4, TIMEOUT=8.
module tb_jtag_ahb_req_queue;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        update_dr = 1'b0;
  logic        ahb_select = 1'b0;
  logic        lsb_en = 1'b0;
  logic [64:0] cmd_in = '0;
  logic        ack = 1'b0;
  logic        err = 1'b0;
  logic        clr_status = 1'b0;
  logic        ahb_enable;
  logic [64:0] cmd_out;
  logic [2:0]  pending;
  logic        full;
  logic        overflow_flag;
  logic        timeout_flag;
  logic        err_flag;

  int tests = 0;
  int fails = 0;
  int cnt;
  logic [64:0] cmds [4];

  always #5 CLK = ~CLK;

  jtag_ahb_req_queue #(
    .CMD_W   (65),
    .DEPTH   (4),
    .TIMEOUT (8)
  ) dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .update_dr     (update_dr),
    .ahb_select    (ahb_select),
    .lsb_en        (lsb_en),
    .cmd_in        (cmd_in),
    .ack           (ack),
    .err           (err),
    .clr_status    (clr_status),
    .ahb_enable    (ahb_enable),
    .cmd_out       (cmd_out),
    .pending       (pending),
    .full          (full),
    .overflow_flag (overflow_flag),
    .timeout_flag  (timeout_flag),
    .err_flag      (err_flag)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    tick();
    tick();
    nRST = 1'b1;
  endtask

  task automatic cap_on(input logic [64:0] v);
    update_dr = 1'b1; ahb_select = 1'b1; lsb_en = 1'b1; cmd_in = v;
  endtask

  task automatic cap_off();
    update_dr = 1'b0; ahb_select = 1'b0; lsb_en = 1'b0;
  endtask

  initial begin
    cmds[0] = 65'h0_11111111_00000010;
    cmds[1] = 65'h1_22222222_00000020;
    cmds[2] = 65'h0_33333333_00000030;
    cmds[3] = 65'h1_44444444_00000040;

    // Reset state
    do_reset();
    check("rst_en", ahb_enable, 0);
    check("rst_pending", pending, 0);
    check("rst_full", full, 0);
    check("rst_flags", {overflow_flag, timeout_flag, err_flag}, 0);
    check("rst_cmd_out", cmd_out, 0);

    // 1: single capture, latency, ack after 3 cycles
    cap_on(65'h1_DEADBEEF_00001000);
    tick();
    cap_off();
    check("t1_en_k", ahb_enable, 0);
    check("t1_pend_k", pending, 1);
    tick();
    check("t1_en_k1", ahb_enable, 1);
    check("t1_cmd", cmd_out, 65'h1_DEADBEEF_00001000);
    tick();
    tick();
    check("t1_en_hold", ahb_enable, 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("t1_en_done", ahb_enable, 0);
    check("t1_pend_done", pending, 0);
    check("t1_flags", {overflow_flag, timeout_flag, err_flag}, 0);

    // 2: four back-to-back captures, in-order issue, one-cycle gaps
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cap_on(cmds[i]);
      tick();
    end
    cap_off();
    check("t2_full", full, 1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        check($sformatf("t2_gap%0d", i), ahb_enable, 0);
        tick();
      end
      check($sformatf("t2_en%0d", i), ahb_enable, 1);
      check($sformatf("t2_cmd%0d", i), cmd_out, cmds[i]);
      check($sformatf("t2_pend%0d", i), pending, 4 - i);
      tick();
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check($sformatf("t2_pend_after%0d", i), pending, 3 - i);
    end
    tick();
    check("t2_idle", ahb_enable, 0);

    // 3: overflow while full, then push accepted on a pop edge
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cap_on(cmds[i]);
      tick();
    end
    cap_on(65'h0_0BAD0BAD_0000DEAD);
    tick();
    cap_off();
    check("t3_ovf_pend", pending, 4);
    check("t3_ovf_flag", overflow_flag, 1);
    check("t3_ovf_full", full, 1);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check("t3_clr_ovf", overflow_flag, 0);
    cap_on(65'h1_55555555_00000050);
    ack = 1'b1;
    tick();
    cap_off();
    ack = 1'b0;
    check("t3_swap_pend", pending, 4);
    check("t3_swap_ovf", overflow_flag, 0);
    check("t3_swap_en", ahb_enable, 0);
    check("t3_swap_head", cmd_out, cmds[1]);

    // 4: timeout abort after exactly 8 cycles, then ack on the 8th cycle
    do_reset();
    cap_on(65'h0_66666666_00000060);
    tick();
    cap_off();
    tick();
    cnt = 0;
    while (ahb_enable && cnt < 20) begin
      cnt++;
      tick();
    end
    check("t4_high_cycles", cnt, 8);
    check("t4_to_flag", timeout_flag, 1);
    check("t4_pend", pending, 0);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check("t4_clr", timeout_flag, 0);
    cap_on(65'h1_77777777_00000070);
    tick();
    cap_off();
    tick();
    repeat (7) tick();
    check("t4_en_8th", ahb_enable, 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("t4_ack_en", ahb_enable, 0);
    check("t4_ack_pend", pending, 0);
    check("t4_ack_noto", timeout_flag, 0);

    // 5: error capture, clear, set-wins-over-clear
    cap_on(65'h0_88888888_00000080);
    tick();
    cap_off();
    tick();
    ack = 1'b1; err = 1'b1;
    tick();
    ack = 1'b0; err = 1'b0;
    check("t5_err", err_flag, 1);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check("t5_clr_all", {overflow_flag, timeout_flag, err_flag}, 0);
    cap_on(65'h1_99999999_00000090);
    tick();
    cap_off();
    tick();
    ack = 1'b1; err = 1'b1; clr_status = 1'b1;
    tick();
    ack = 1'b0; err = 1'b0; clr_status = 1'b0;
    check("t5_set_wins", err_flag, 1);

    // 6: asynchronous reset mid-REQ with 3 pending, then stray ack in IDLE
    for (int i = 0; i < 3; i++) begin
      cap_on(cmds[i]);
      tick();
    end
    cap_off();
    check("t6_pre_en", ahb_enable, 1);
    check("t6_pre_pend", pending, 3);
    #3;
    nRST = 1'b0;
    #1;
    check("t6_rst_en", ahb_enable, 0);
    check("t6_rst_pend", pending, 0);
    check("t6_rst_flags", {overflow_flag, timeout_flag, err_flag}, 0);
    tick();
    nRST = 1'b1;
    ack = 1'b1; err = 1'b1;
    tick();
    ack = 1'b0; err = 1'b0;
    tick();
    check("t6_stray_en", ahb_enable, 0);
    check("t6_stray_pend", pending, 0);
    check("t6_stray_flags", {overflow_flag, timeout_flag, err_flag}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
